// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: victim writeback engine for the data cache.
// Reads one line from the data RAM and drains it as an 8-beat AXI4 burst.
module dcache_wb_buffer #(
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned TAG_WIDTH   = 20,
  parameter logic [3:0]  AXI_ID      = 4'd1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   ram_en,
  output logic [INDEX_WIDTH-1:0] ram_rindex,
  input  logic [255:0]           ram_rdata,
  input  logic [INDEX_WIDTH-1:0] chk_index,
  input  logic [TAG_WIDTH-1:0]   chk_tag,
  output logic                   chk_hit,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready,
  output logic                   busy
);

  if (TAG_WIDTH + INDEX_WIDTH + 5 != 32) begin : g_bad_width
    $error("dcache_wb_buffer: tag+index+offset must be 32 bits");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD,
    AW,
    W,
    B
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0]             beat;
  logic [255:0]           line;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] idx_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == AW && awready) begin
        beat <= '0;
      end else if (state == W && wready) begin
        beat <= beat + 3'd1;
      end
    end
  end

  // Datapath holding registers carry no reset; they are only
  // consumed in states that are reached after being loaded.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      tag_q <= req_tag;
      idx_q <= req_index;
    end
    if (state == RD) begin
      line <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ram_en    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ram_en    = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        state_nxt = AW;
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) begin
          state_nxt = W;
        end
      end
      W: begin
        wvalid = 1'b1;
        if (wready && beat == 3'd7) begin
          state_nxt = B;
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ram_rindex = req_index;

  assign awid    = AXI_ID;
  assign awaddr  = {tag_q, idx_q, 5'b0};
  assign awlen   = 8'd7;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;

  // Beat 0 is the lowest-addressed word of the line.
  assign wdata = line[{beat, 5'b0} +: 32];
  assign wstrb = 4'hf;
  assign wlast = (state == W) && (beat == 3'd7);

  assign busy = (state != IDLE);

  assign chk_hit = busy
                && (chk_index == idx_q)
                && (chk_tag == tag_q);

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: scoreboard bench for the writeback engine.
// RAM and AXI slave models drive the DUT; beats are checked in order.
module tb_dcache_wb_buffer;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_index;
  logic [19:0]  req_tag;
  logic         ram_en;
  logic [6:0]   ram_rindex;
  logic [255:0] ram_rdata;
  logic [6:0]   chk_index;
  logic [19:0]  chk_tag;
  logic         chk_hit;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;
  logic         busy;

  always #5 clk = ~clk;

  dcache_wb_buffer #(
    .INDEX_WIDTH(7),
    .TAG_WIDTH  (20),
    .AXI_ID     (4'd1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_index (req_index),
    .req_tag   (req_tag),
    .ram_en    (ram_en),
    .ram_rindex(ram_rindex),
    .ram_rdata (ram_rdata),
    .chk_index (chk_index),
    .chk_tag   (chk_tag),
    .chk_hit   (chk_hit),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int idx, input int i);
    if (idx == 'h15) return 32'h1000_0000 + 32'(i);
    return 32'h2000_0000 + 32'(idx << 8) + 32'(i);
  endfunction

  logic [255:0] mem [128];

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_rindex];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave controls
  int aw_delay;
  bit w_toggle;

  // Monitor-owned state
  beat_t       exp_w[$];
  logic [31:0] exp_a[$];
  beat_t       tmp_b;
  int          acc_cnt = 0;
  int          wlast_cnt = 0;
  int          b_cnt = 0;
  int          acc_cyc = 0;
  int          aw_cyc = 0;
  int          b_cyc = 0;
  int          acc_gap = 0;
  int          aw_cycles = 0;
  int          burst_beats = 0;
  int          hold3 = 0;
  bit          aw_seen = 0;
  bit          aw_done = 0;
  bit          post_b = 0;
  bit          aw_hold = 0;
  bit          w_hold = 0;
  logic [31:0] prev_awaddr;
  logic [31:0] prev_wdata;
  logic        prev_wlast;
  logic [31:0] last_awaddr;
  logic [6:0]  last_rindex;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_w.delete();
      exp_a.delete();
      aw_hold = 0;
      w_hold  = 0;
      post_b  = 0;
      aw_seen = 0;
      aw_done = 0;
    end else begin
      if (post_b) begin
        check("busy_after_b", 32'(busy), 32'd0);
        check("chk_after_b", 32'(chk_hit), 32'd0);
        check("ready_after_b", 32'(req_ready), 32'd1);
        post_b = 0;
      end
      if (busy) check("ready_busy", 32'(req_ready), 32'd0);
      if (req_valid && req_ready) begin
        check("ram_en_req", 32'(ram_en), 32'd1);
        check("ram_rindex", 32'(ram_rindex), 32'(req_index));
        last_rindex = ram_rindex;
        for (int i = 0; i < 8; i++) begin
          tmp_b.d = word_of(int'(req_index), i);
          tmp_b.l = (i == 7);
          exp_w.push_back(tmp_b);
        end
        exp_a.push_back({req_tag, req_index, 5'b0});
        acc_gap = cyc - b_cyc;
        acc_cyc = cyc;
        acc_cnt++;
        aw_seen = 0;
        aw_done = 0;
        aw_cycles = 0;
      end else begin
        check("ram_en_idle", 32'(ram_en), 32'd0);
      end
      if (awvalid) begin
        if (!aw_seen) aw_cyc = cyc;
        aw_seen = 1;
        aw_cycles++;
        check("w_during_aw", 32'(wvalid), 32'd0);
        if (aw_hold) check("awaddr_stable", awaddr, prev_awaddr);
        if (awready) begin
          if (exp_a.size() == 0) begin
            check("aw_unexpected", 32'd1, 32'd0);
          end else begin
            check("awaddr", awaddr, exp_a.pop_front());
          end
          check("awlen", 32'(awlen), 32'd7);
          check("awsize", 32'(awsize), 32'd2);
          check("awburst", 32'(awburst), 32'd1);
          check("awid", 32'(awid), 32'd1);
          last_awaddr = awaddr;
          aw_done = 1;
          burst_beats = 0;
          hold3 = 0;
        end
        aw_hold = !awready;
        prev_awaddr = awaddr;
      end else begin
        aw_hold = 0;
      end
      if (wvalid) begin
        check("w_before_aw", 32'(aw_done), 32'd1);
        if (w_hold) begin
          check("wdata_stable", wdata, prev_wdata);
          check("wlast_stable", 32'(wlast), 32'(prev_wlast));
        end
        if (exp_w.size() == 0) begin
          check("w_unexpected", 32'd1, 32'd0);
        end else begin
          check("wdata", wdata, exp_w[0].d);
          check("wlast", 32'(wlast), 32'(exp_w[0].l));
          if (wready) void'(exp_w.pop_front());
        end
        if (!wready && burst_beats == 3) hold3++;
        if (wready) begin
          check("wstrb", 32'(wstrb), 32'hf);
          burst_beats++;
          if (wlast) wlast_cnt++;
        end
        w_hold = !wready;
        prev_wdata = wdata;
        prev_wlast = wlast;
      end else begin
        w_hold = 0;
      end
      if (bvalid && bready) begin
        b_cnt++;
        b_cyc = cyc;
        post_b = 1;
      end
    end
  end

  // AXI slave model
  int aw_n;
  int wcyc;
  int seen_wl;
  int seen_b;
  logic [3:0] pat;

  initial begin
    awready = 0;
    wready  = 0;
    bvalid  = 0;
    aw_n    = 0;
    wcyc    = 0;
    seen_wl = 0;
    seen_b  = 0;
    pat     = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        awready = 0;
        wready  = 0;
        bvalid  = 0;
        aw_n    = 0;
        wcyc    = 0;
        seen_wl = wlast_cnt;
        seen_b  = b_cnt;
      end else begin
        if (awvalid) begin
          awready = (aw_n >= aw_delay);
          aw_n++;
        end else begin
          awready = 0;
          aw_n = 0;
        end
        if (wvalid) begin
          wready = w_toggle ? pat[wcyc % 4] : 1'b1;
          wcyc++;
        end else begin
          wready = 0;
          wcyc = 0;
        end
        if (b_cnt != seen_b) begin
          bvalid = 0;
          seen_b = b_cnt;
        end else if (wlast_cnt != seen_wl) begin
          bvalid = 1;
          seen_wl = wlast_cnt;
        end
      end
    end
  end

  task automatic issue(input logic [6:0] idx, input logic [19:0] tag);
    int start;
    int k;
    start = acc_cnt;
    req_valid = 1;
    req_index = idx;
    req_tag   = tag;
    chk_index = idx;
    chk_tag   = tag;
    k = 0;
    while (acc_cnt == start && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("req_accept", 32'(acc_cnt != start), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (b_cnt < target && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("b_done", 32'(b_cnt >= target), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int tgt;
  int k;

  initial begin
    for (int x = 0; x < 128; x++) begin
      for (int i = 0; i < 8; i++) mem[x][i*32 +: 32] = word_of(x, i);
    end
    resetn    = 0;
    req_valid = 0;
    req_index = '0;
    req_tag   = '0;
    chk_index = '0;
    chk_tag   = '0;
    aw_delay  = 0;
    w_toggle  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wlast", 32'(wlast), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chk_hit", 32'(chk_hit), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    resetn = 1;
    @(posedge clk);
    #1;

    tgt = b_cnt + 1;
    issue(7'h15, 20'hABCDE);
    wait_done(tgt);
    check("basic_rindex", 32'(last_rindex), 32'h15);
    check("basic_awaddr", last_awaddr, 32'hABCDE2A0);
    check("basic_aw_lat", 32'(aw_cyc - acc_cyc), 32'd2);
    check("basic_txn_len", 32'(b_cyc - acc_cyc + 1), 32'd12);
    check("basic_beats", 32'(burst_beats), 32'd8);
    check("basic_busy", 32'(busy), 32'd0);

    aw_delay = 5;
    tgt = b_cnt + 1;
    issue(7'h03, 20'h12345);
    wait_done(tgt);
    check("aw_stall_cycles", 32'(aw_cycles), 32'd6);
    check("aw_stall_beats", 32'(burst_beats), 32'd8);
    aw_delay = 0;

    w_toggle = 1;
    tgt = b_cnt + 1;
    issue(7'h15, 20'h55555);
    wait_done(tgt);
    check("toggle_beats", 32'(burst_beats), 32'd8);
    check("toggle_hold3", 32'(hold3), 32'd2);
    w_toggle = 0;

    tgt = b_cnt + 2;
    issue(7'h10, 20'h11111);
    issue(7'h11, 20'h22222);
    wait_done(tgt);
    check("b2b_gap", 32'(acc_gap), 32'd1);
    check("b2b_rindex", 32'(last_rindex), 32'h11);
    check("b2b_awaddr", last_awaddr, {20'h22222, 7'h11, 5'b0});

    tgt = b_cnt + 1;
    issue(7'h22, 20'h0F0F0);
    k = 0;
    while (!wvalid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("chk_reach_w", 32'(wvalid), 32'd1);
    check("chk_hit_match", 32'(chk_hit), 32'd1);
    chk_tag = 20'h0F0F1;
    #1;
    check("chk_hit_tagdiff", 32'(chk_hit), 32'd0);
    chk_tag = 20'h0F0F0;
    chk_index = 7'h23;
    #1;
    check("chk_hit_idxdiff", 32'(chk_hit), 32'd0);
    chk_index = 7'h22;
    #1;
    check("chk_hit_again", 32'(chk_hit), 32'd1);
    wait_done(tgt);
    check("chk_hit_done", 32'(chk_hit), 32'd0);

    issue(7'h15, 20'hABCDE);
    k = 0;
    while (!(wvalid && burst_beats == 4) && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_reach_b4", 32'(wvalid && burst_beats == 4), 32'd1);
    #2;
    resetn = 0;
    #1;
    check("mid_rst_awvalid", 32'(awvalid), 32'd0);
    check("mid_rst_wvalid", 32'(wvalid), 32'd0);
    check("mid_rst_wlast", 32'(wlast), 32'd0);
    check("mid_rst_bready", 32'(bready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_chk_hit", 32'(chk_hit), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    @(posedge clk);
    #1;
    tgt = b_cnt + 1;
    issue(7'h05, 20'h0BEEF);
    wait_done(tgt);
    check("post_rst_beats", 32'(burst_beats), 32'd8);
    check("post_rst_awaddr", last_awaddr, {20'h0BEEF, 7'h05, 5'b0});
    check("left_w", 32'(exp_w.size()), 32'd0);
    check("left_aw", 32'(exp_a.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
